// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the RV32M sequencer.
// The pipeline side drives the request fields; the unit returns status and result.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, kill_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, kill_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 multi-cycle RV32M multiply/divide unit.
// One shared adder (multiply accumulate) and one shared XLEN+1-bit subtracter
// (restoring divide step, signed corrections, negations) are reused each cycle.
// {hi_q,lo_q} holds the product accumulator, or remainder/quotient when dividing.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX1,
        FIX2,
        DONE
    } state_t;

    state_t          state_q;
    logic [5:0]      cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            rs1_neg_q;
    logic            rs2_neg_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            rs1_signed;
    logic            rs2_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   sub_min;
    logic [XLEN:0]   sub_sub;
    logic [XLEN:0]   sub_res;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;
    logic [XLEN-1:0] final_d;

    // Decode the incoming request: operand signedness, divide magnitudes, special cases
    always_comb begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        if (bus.op_i[2]) begin
            rs1_signed = ~bus.op_i[0];
            rs2_signed = ~bus.op_i[0];
        end else begin
            rs1_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010);
            rs2_signed = (bus.op_i == 3'b001);
        end
        rs1_neg  = rs1_signed & bus.rs1_i[XLEN-1];
        rs2_neg  = rs2_signed & bus.rs2_i[XLEN-1];
        mag1     = (bus.op_i[2] && rs1_neg) ? -bus.rs1_i : bus.rs1_i;
        mag2     = (bus.op_i[2] && rs2_neg) ? -bus.rs2_i : bus.rs2_i;
        div_zero = bus.op_i[2] && (bus.rs2_i == '0);
        div_ovf  = bus.op_i[2] && !bus.op_i[0] &&
                   (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = bus.op_i[1] ? bus.rs1_i : '1;
        end else if (div_ovf) begin
            special_res = bus.op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Shared adder/subtracter datapath: next accumulator value for the current step
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        sub_min = '0;
        sub_sub = '0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            CALC: begin
                if (op_q[2]) begin
                    sub_min = {hi_q, lo_q[XLEN-1]};
                    sub_sub = {1'b0, b_q};
                end
            end
            FIX1: begin
                if (op_q[2]) begin
                    sub_sub = {1'b0, lo_q};
                end else begin
                    sub_min = {1'b0, hi_q};
                    sub_sub = rs1_neg_q ? {1'b0, b_q} : '0;
                end
            end
            FIX2: begin
                if (op_q[2]) begin
                    sub_sub = {1'b0, hi_q};
                end else begin
                    sub_min = {1'b0, hi_q};
                    sub_sub = rs2_neg_q ? {1'b0, a_q} : '0;
                end
            end
            default: begin
                sub_min = '0;
                sub_sub = '0;
            end
        endcase
        sub_res = sub_min - sub_sub;
        case (state_q)
            CALC: begin
                if (op_q[2]) begin
                    if (!sub_res[XLEN]) begin
                        hi_d = sub_res[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = sub_min[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = add_sum[XLEN:1];
                    lo_d = {add_sum[0], lo_q[XLEN-1:1]};
                end
            end
            FIX1: begin
                if (op_q[2]) begin
                    if (rs1_neg_q ^ rs2_neg_q) begin
                        lo_d = sub_res[XLEN-1:0];
                    end
                end else begin
                    hi_d = sub_res[XLEN-1:0];
                end
            end
            FIX2: begin
                if (op_q[2]) begin
                    if (rs1_neg_q) begin
                        hi_d = sub_res[XLEN-1:0];
                    end
                end else begin
                    hi_d = sub_res[XLEN-1:0];
                end
            end
            default: begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        endcase
        if (op_q[2]) begin
            final_d = op_q[1] ? hi_d : lo_d;
        end else begin
            final_d = (op_q == 3'b000) ? lo_d : hi_d;
        end
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            rs1_neg_q <= 1'b0;
            rs2_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && bus.kill_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_i && !bus.kill_i) begin
                            op_q      <= bus.op_i;
                            a_q       <= mag1;
                            b_q       <= mag2;
                            hi_q      <= '0;
                            lo_q      <= bus.op_i[2] ? mag1 : bus.rs2_i;
                            rs1_neg_q <= rs1_neg;
                            rs2_neg_q <= rs2_neg;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            if (div_zero || div_ovf) begin
                                result_q <= special_res;
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(XLEN-1)) begin
                            state_q <= FIX1;
                        end
                    end
                    FIX1: begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        state_q <= FIX2;
                    end
                    FIX2: begin
                        hi_q     <= hi_d;
                        lo_q     <= lo_d;
                        result_q <= final_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, special-case
// divides, ignored starts, kill and reset aborts, then randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_sequencer;
    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;
    int   failCount;
    logic [31:0] lastResult;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of an RV32M operation, computed with wide arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        int sa32;
        int sb32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa32 = $signed(a);
        sb32 = $signed(b);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa32 / sb32);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa32 % sb32);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Divides by zero and signed overflow finish without iterating
    function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 35;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        assert (actual === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, actual, expected);
        end
    endtask

    // Present one request for exactly one sampling edge (called right after a negedge)
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Full transaction: result, done timing, busy length, return to idle
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int busyCnt;
        int expLat;
        bit saw;
        exp = refModel(op, a, b);
        expLat = expLatency(op, a, b);
        applyStimulus(op, a, b);
        saw = 0;
        lat = 0;
        busyCnt = 0;
        for (int n = 1; n <= 60 && !saw; n++) begin
            @(negedge clk);
            if (bus.busy_o) busyCnt++;
            if (bus.done_o) begin
                saw = 1;
                lat = n;
            end
        end
        checkOutput({tag, "_done"}, 32'(saw), 32'd1);
        checkOutput({tag, "_result"}, bus.result_o, exp);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'(expLat));
        @(negedge clk);
        checkOutput({tag, "_idle"}, {30'b0, bus.busy_o, bus.done_o}, 32'd0);
        lastResult = exp;
    endtask

    initial begin
        int doneCnt;
        int doneAt;
        logic [31:0] res;
        logic [31:0] exp;
        logic busyAt36;
        logic busyAt21;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        int sel;

        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        lastResult = '0;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.op_i    = '0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("reset_done", {31'b0, bus.done_o}, 32'd0);
        checkOutput("reset_result", bus.result_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed multiply and divide");
        runOp("mul_7x6", 3'd0, 32'd7, 32'd6);
        runOp("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        runOp("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        runOp("divu_big_2", 3'd5, 32'hFFFF_FFF9, 32'd2);
        runOp("divu_near_max", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        $display("[TB] special-case divides");
        runOp("divu_by0", 3'd5, 32'd5, 32'd0);
        runOp("remu_by0", 3'd7, 32'd5, 32'd0);
        runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        $display("[TB] start ignored while busy and in DONE");
        exp = refModel(3'd0, 32'd123456, 32'd789);
        applyStimulus(3'd0, 32'd123456, 32'd789);
        doneCnt = 0;
        doneAt = 0;
        res = '0;
        busyAt36 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done_o) begin
                doneCnt++;
                doneAt = n;
                res = bus.result_o;
            end
            if (n == 36) busyAt36 = bus.busy_o;
            bus.op_i    = 3'd5;
            bus.rs1_i   = 32'd99;
            bus.rs2_i   = 32'd0;
            bus.start_i = (n == 10 || n == 35);
        end
        bus.start_i = 1'b0;
        checkOutput("ignore_donecount", 32'(doneCnt), 32'd1);
        checkOutput("ignore_doneat", 32'(doneAt), 32'd35);
        checkOutput("ignore_result", res, exp);
        checkOutput("ignore_idle36", {31'b0, busyAt36}, 32'd0);
        lastResult = exp;

        $display("[TB] kill during CALC");
        applyStimulus(3'd4, 32'd1000, 32'd7);
        doneCnt = 0;
        busyAt21 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done_o) doneCnt++;
            if (n == 21) busyAt21 = bus.busy_o;
            bus.kill_i = (n == 20);
        end
        bus.kill_i = 1'b0;
        checkOutput("kill_nodone", 32'(doneCnt), 32'd0);
        checkOutput("kill_idle21", {31'b0, busyAt21}, 32'd0);
        checkOutput("kill_result_held", bus.result_o, lastResult);
        runOp("after_kill", 3'd5, 32'd100, 32'd7);

        $display("[TB] reset during CALC");
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("midrst_done", {31'b0, bus.done_o}, 32'd0);
        checkOutput("midrst_result", bus.result_o, 32'd0);
        rst = 1'b0;
        lastResult = '0;
        @(negedge clk);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 3) a = 32'($urandom_range(0, 255));
            runOp($sformatf("rand%0d_op%0d", i, op), op, a, b);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
